// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Package : i2s_pkg
// Purpose : Shared frame geometry, slot type and SCK divider helper for the
//           I2S transmit path.
// Rev     : 1.0
// ============================================================================
package i2s_pkg;

  localparam int SLOTS_PER_FRAME   = 64;
  localparam int SLOTS_PER_CHANNEL = 32;
  localparam int LOAD_SLOT         = 63;
  localparam int WS_RISE_SLOT      = 31;

  typedef logic [$clog2(SLOTS_PER_FRAME)-1:0] slot_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

  function automatic int calc_half_div(input int clk_freq, input int sck_freq);
    return clk_freq / (2 * sck_freq);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : i2s_tx_fifo
// Purpose : Synchronous sample FIFO; ready_o is registered "not full next cycle".
// Rev     : 1.0
// ============================================================================
module i2s_tx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ready_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             ready_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign ready_o = ready_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d != FULL_CNT);
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/i2s_transmit.sv
`default_nettype none
// ============================================================================
// Module  : i2s_transmit
// Purpose : Mono Philips-I2S master transmitter fed by a valid/ready FIFO.
//           Define I2S_TRANSMIT_HOLD_LAST_EN to repeat the last sample on underrun.
// Rev     : 1.0
// ============================================================================
module i2s_transmit #(
  parameter int DATA_IN_SIZE  = 16,
  parameter int I2S_DATA_SIZE = 24,
  parameter int CLK_FREQ      = 100_000_000,
  parameter int I2S_CLK_FREQ  = 1_500_000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_IN_SIZE-1:0] pcm_in,
  input  logic                    pcm_valid,
  output logic                    pcm_ready,
  output logic                    i2s_clk,
  output logic                    i2s_ws,
  output logic                    i2s_sd,
  output logic                    underrun
);

  import i2s_pkg::*;

  localparam int HALF_DIV = calc_half_div(CLK_FREQ, I2S_CLK_FREQ);
  localparam int DIV_W    = $clog2(HALF_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
  localparam int PAD      = I2S_DATA_SIZE - DATA_IN_SIZE;
  localparam int CH_W     = $clog2(SLOTS_PER_CHANNEL);

  logic [DIV_W-1:0]          div_q, div_d;
  logic                      sck_q, sck_d;
  slot_t                     slot_q, slot_d, slot_nxt;
  channel_e                  ws_q, ws_d;
  logic                      sd_q, sd_d;
  logic                      urun_q, urun_d;
  logic [I2S_DATA_SIZE-1:0]  word_q, word_d;
  logic [SLOTS_PER_CHANNEL-1:0] word_pad;
  logic [CH_W-1:0]           bit_idx;
  logic                      tick;
  logic                      fall_evt;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic [DATA_IN_SIZE-1:0]   fifo_data;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_ready;

  assign tick      = (div_q == DIV_LAST);
  assign fall_evt  = tick && sck_q;
  assign slot_nxt  = slot_q + 1'b1;
  assign bit_idx   = slot_nxt[CH_W-1:0];
  // Word left-justified in a 32-bit slot: bits past the word read as zero.
  assign word_pad  = SLOTS_PER_CHANNEL'(word_q) << (SLOTS_PER_CHANNEL - I2S_DATA_SIZE);
  assign fifo_push = pcm_valid && fifo_ready && !fifo_full;

  i2s_tx_fifo #(
    .WIDTH (DATA_IN_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (pcm_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .ready_o (fifo_ready)
  );

  always_comb begin
    div_d    = div_q + 1'b1;
    sck_d    = sck_q;
    slot_d   = slot_q;
    ws_d     = ws_q;
    sd_d     = sd_q;
    word_d   = word_q;
    urun_d   = 1'b0;
    fifo_pop = 1'b0;
    if (tick) begin
      div_d = '0;
      sck_d = ~sck_q;
    end
    if (fall_evt) begin
      slot_d = slot_nxt;
      ws_d   = (slot_nxt >= slot_t'(WS_RISE_SLOT) && slot_nxt != slot_t'(LOAD_SLOT))
               ? CH_RIGHT : CH_LEFT;
      sd_d   = word_pad[~bit_idx];
      if (slot_nxt == slot_t'(LOAD_SLOT)) begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          word_d   = I2S_DATA_SIZE'(fifo_data) << PAD;
        end else begin
          urun_d = 1'b1;
`ifdef I2S_TRANSMIT_HOLD_LAST_EN
          word_d = word_q;
`else
          word_d = '0;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      sck_q  <= 1'b0;
      slot_q <= slot_t'(LOAD_SLOT);
      ws_q   <= CH_LEFT;
      sd_q   <= 1'b0;
      urun_q <= 1'b0;
      word_q <= '0;
    end else begin
      div_q  <= div_d;
      sck_q  <= sck_d;
      slot_q <= slot_d;
      ws_q   <= ws_d;
      sd_q   <= sd_d;
      urun_q <= urun_d;
      word_q <= word_d;
    end
  end

  assign pcm_ready = fifo_ready;
  assign i2s_clk   = sck_q;
  assign i2s_ws    = ws_q;
  assign i2s_sd    = sd_q;
  assign underrun  = urun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_transmit.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2s_transmit
// Purpose : Directed self-checking bench for i2s_transmit at default parameters.
// Rev     : 1.0
// ============================================================================
module tb_i2s_transmit;

  localparam logic [63:0] WS_EXP = 64'h7FFF_FFFF_8000_0000;
`ifdef I2S_TRANSMIT_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pcm_in = '0;
  logic        pcm_valid = 1'b0;
  logic        pcm_ready, i2s_clk, i2s_ws, i2s_sd, underrun;

  i2s_transmit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pcm_in    (pcm_in),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .i2s_clk   (i2s_clk),
    .i2s_ws    (i2s_ws),
    .i2s_sd    (i2s_sd),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int urun_cnt = 0;
  int acc_cnt  = 0;
  int stream_limit = 0;
  bit stream_on = 1'b0;
  bit mon_en    = 1'b0;
  bit fall, pushed;
  logic sck_prev = 1'b0, ws_prev = 1'b0;
  int last_rise = -1, last_fall = -1, last_ws_rise = -1;
  int per_min = 1000000, per_max = 0, hi_min = 1000000, hi_max = 0;
  int lo_min = 1000000, lo_max = 0, wsp_min = 1000000, wsp_max = 0, ws_bad = 0;

  function automatic logic [63:0] exp_sd(input logic [23:0] w);
    logic [63:0] r;
    r = '0;
    for (int s = 0; s < 64; s++) begin
      int i;
      i = s % 32;
      if (i < 24) r[s] = w[23-i];
    end
    return r;
  endfunction

  task automatic tick();
    int d;
    pushed = pcm_valid && pcm_ready;
    @(negedge clk);
    cyc++;
    fall = sck_prev && !i2s_clk;
    if (pushed) begin
      acc_cnt++;
      if (stream_on) begin
        pcm_in = pcm_in + 16'd1;
        if (acc_cnt >= stream_limit) begin
          stream_on = 1'b0;
          pcm_valid = 1'b0;
        end
      end
    end
    if (underrun) urun_cnt++;
    if (mon_en) begin
      if (!sck_prev && i2s_clk) begin
        if (last_rise >= 0) begin
          d = cyc - last_rise;
          if (d < per_min) per_min = d;
          if (d > per_max) per_max = d;
        end
        if (last_fall >= 0) begin
          d = cyc - last_fall;
          if (d < lo_min) lo_min = d;
          if (d > lo_max) lo_max = d;
        end
        last_rise = cyc;
      end
      if (fall) begin
        if (last_rise >= 0) begin
          d = cyc - last_rise;
          if (d < hi_min) hi_min = d;
          if (d > hi_max) hi_max = d;
        end
        last_fall = cyc;
      end
      if (i2s_ws !== ws_prev) begin
        if (!fall) ws_bad++;
        if (i2s_ws) begin
          if (last_ws_rise >= 0) begin
            d = cyc - last_ws_rise;
            if (d < wsp_min) wsp_min = d;
            if (d > wsp_max) wsp_max = d;
          end
          last_ws_rise = cyc;
        end
      end
    end
    sck_prev = i2s_clk;
    ws_prev  = i2s_ws;
  endtask

  task automatic next_fall(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (fall) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Walks one frame (slots 0..63) starting just after a slot-63 fall.
  task automatic run_frame(input bit push_en, input logic [15:0] push_val,
                           output logic [63:0] sd_bits, output logic [63:0] ws_bits,
                           output int urun, output bit push_hit, output bit ok);
    int u0;
    bit f_ok;
    u0 = urun_cnt;
    ok = 1'b1;
    push_hit = 1'b0;
    sd_bits = '0;
    ws_bits = '0;
    for (int k = 0; k < 64; k++) begin
      if (push_en && k == 63) begin
        f_ok = 1'b1;
        for (int j = 0; j < 65; j++) begin
          tick();
          if (fall) f_ok = 1'b0;
        end
        pcm_in    = push_val;
        pcm_valid = 1'b1;
        tick();
        push_hit  = pushed && fall;
        if (!fall) f_ok = 1'b0;
        pcm_valid = 1'b0;
      end else begin
        next_fall(f_ok);
      end
      if (!f_ok) ok = 1'b0;
      sd_bits[k] = i2s_sd;
      ws_bits[k] = i2s_ws;
    end
    urun = urun_cnt - u0;
  endtask

  logic [63:0] sdb, wsb;
  int          u;
  bit          ph, ok;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (i2s_clk !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b expected 0", i2s_clk); end
    n_checks++; if (i2s_ws !== 1'b0) begin n_fail++; $display("FAIL reset_ws: got %b expected 0", i2s_ws); end
    n_checks++; if (i2s_sd !== 1'b0) begin n_fail++; $display("FAIL reset_sd: got %b expected 0", i2s_sd); end
    n_checks++; if (pcm_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", pcm_ready); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    rst_n = 1'b1;
    sck_prev = 1'b0;
    ws_prev  = 1'b0;
    mon_en   = 1'b1;
    tick();
    n_checks++; if (pcm_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_release: got %b expected 1", pcm_ready); end
  endtask

  task automatic test_single_sample();
    pcm_in = 16'h8001;
    pcm_valid = 1'b1;
    tick();
    pcm_valid = 1'b0;
    n_checks++; if (pushed !== 1'b1) begin n_fail++; $display("FAIL single_push: got %b expected 1", pushed); end
    run_frame(1'b0, 16'h0, sdb, wsb, u, ph, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL frame1_timeout: got %b expected 1", ok); end
    n_checks++; if (sdb !== 64'h0) begin n_fail++; $display("FAIL frame1_sd: got %h expected %h", sdb, 64'h0); end
    n_checks++; if (wsb !== WS_EXP) begin n_fail++; $display("FAIL frame1_ws: got %h expected %h", wsb, WS_EXP); end
    n_checks++; if (u !== 0) begin n_fail++; $display("FAIL frame1_underrun: got %0d expected 0", u); end
    run_frame(1'b0, 16'h0, sdb, wsb, u, ph, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL frame2_timeout: got %b expected 1", ok); end
    n_checks++; if (sdb !== exp_sd(24'h800100)) begin n_fail++; $display("FAIL frame2_sd: got %h expected %h", sdb, exp_sd(24'h800100)); end
    n_checks++; if (wsb !== WS_EXP) begin n_fail++; $display("FAIL frame2_ws: got %h expected %h", wsb, WS_EXP); end
    n_checks++; if (u !== 1) begin n_fail++; $display("FAIL frame2_underrun: got %0d expected 1", u); end
  endtask

  task automatic test_underrun();
    logic [63:0] e;
    e = exp_sd(HOLD ? 24'h800100 : 24'h0);
    run_frame(1'b0, 16'h0, sdb, wsb, u, ph, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL frame3_timeout: got %b expected 1", ok); end
    n_checks++; if (sdb !== e) begin n_fail++; $display("FAIL underrun_frame_sd: got %h expected %h", sdb, e); end
    n_checks++; if (u !== 1) begin n_fail++; $display("FAIL underrun_pulse: got %0d expected 1", u); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] w;
    logic [63:0] e;
    acc_cnt = 0;
    pcm_in = 16'd1;
    stream_limit = 5;
    stream_on = 1'b1;
    pcm_valid = 1'b1;
    repeat (10) tick();
    n_checks++; if (acc_cnt !== 4) begin n_fail++; $display("FAIL b2b_fill: got %0d expected 4", acc_cnt); end
    n_checks++; if (pcm_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %b expected 0", pcm_ready); end
    e = exp_sd(HOLD ? 24'h800100 : 24'h0);
    run_frame(1'b0, 16'h0, sdb, wsb, u, ph, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL frame4_timeout: got %b expected 1", ok); end
    n_checks++; if (sdb !== e) begin n_fail++; $display("FAIL frame4_sd: got %h expected %h", sdb, e); end
    repeat (3) tick();
    n_checks++; if (acc_cnt !== 5) begin n_fail++; $display("FAIL b2b_one_more: got %0d expected 5", acc_cnt); end
    n_checks++; if (pcm_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_refull: got %b expected 0", pcm_ready); end
    for (int v = 1; v <= 5; v++) begin
      w = {v[15:0], 8'h00};
      run_frame(1'b0, 16'h0, sdb, wsb, u, ph, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout_%0d: got %b expected 1", v, ok); end
      n_checks++; if (sdb !== exp_sd(w)) begin n_fail++; $display("FAIL b2b_sample_%0d: got %h expected %h", v, sdb, exp_sd(w)); end
      n_checks++; if (u !== ((v == 5) ? 1 : 0)) begin n_fail++; $display("FAIL b2b_underrun_%0d: got %0d expected %0d", v, u, (v == 5) ? 1 : 0); end
    end
  endtask

  task automatic test_coincident_push();
    logic [63:0] e;
    e = exp_sd(HOLD ? 24'h000500 : 24'h0);
    run_frame(1'b1, 16'h1234, sdb, wsb, u, ph, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL coin_timeout: got %b expected 1", ok); end
    n_checks++; if (ph !== 1'b1) begin n_fail++; $display("FAIL coin_push_at_load: got %b expected 1", ph); end
    n_checks++; if (u !== 1) begin n_fail++; $display("FAIL coin_underrun: got %0d expected 1", u); end
    run_frame(1'b0, 16'h0, sdb, wsb, u, ph, ok);
    n_checks++; if (sdb !== e) begin n_fail++; $display("FAIL coin_no_bypass_sd: got %h expected %h", sdb, e); end
    n_checks++; if (u !== 0) begin n_fail++; $display("FAIL coin_pop_next: got %0d expected 0", u); end
    run_frame(1'b0, 16'h0, sdb, wsb, u, ph, ok);
    n_checks++; if (sdb !== exp_sd(24'h123400)) begin n_fail++; $display("FAIL coin_sample_late: got %h expected %h", sdb, exp_sd(24'h123400)); end
    n_checks++; if (u !== 1) begin n_fail++; $display("FAIL coin_after_underrun: got %0d expected 1", u); end
  endtask

  task automatic test_clock();
    n_checks++; if (per_min !== 66 || per_max !== 66) begin n_fail++; $display("FAIL sck_period: got %0d..%0d expected 66", per_min, per_max); end
    n_checks++; if (hi_min !== 33 || hi_max !== 33) begin n_fail++; $display("FAIL sck_high: got %0d..%0d expected 33", hi_min, hi_max); end
    n_checks++; if (lo_min !== 33 || lo_max !== 33) begin n_fail++; $display("FAIL sck_low: got %0d..%0d expected 33", lo_min, lo_max); end
    n_checks++; if (wsp_min !== 4224 || wsp_max !== 4224) begin n_fail++; $display("FAIL ws_period: got %0d..%0d expected 4224", wsp_min, wsp_max); end
    n_checks++; if (ws_bad !== 0) begin n_fail++; $display("FAIL ws_edge_align: got %0d expected 0", ws_bad); end
  endtask

  task automatic test_reset_mid();
    bit f_ok;
    acc_cnt = 0;
    pcm_in = 16'h7ABC;
    stream_limit = 3;
    stream_on = 1'b1;
    pcm_valid = 1'b1;
    repeat (4) tick();
    n_checks++; if (acc_cnt !== 3) begin n_fail++; $display("FAIL mid_fill: got %0d expected 3", acc_cnt); end
    for (int k = 0; k <= 40; k++) next_fall(f_ok);
    for (int i = 0; i < 40 && i2s_clk !== 1'b1; i++) tick();
    n_checks++; if (i2s_ws !== 1'b1 || i2s_clk !== 1'b1) begin n_fail++; $display("FAIL mid_pre_reset: got ws=%b sck=%b expected 1 1", i2s_ws, i2s_clk); end
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({i2s_clk, i2s_ws, i2s_sd, pcm_ready, underrun} !== 5'b0)
      begin n_fail++; $display("FAIL mid_reset_outputs: got %b expected 00000", {i2s_clk, i2s_ws, i2s_sd, pcm_ready, underrun}); end
    repeat (2) tick();
    rst_n = 1'b1;
    sck_prev = 1'b0;
    ws_prev  = 1'b0;
    tick();
    n_checks++; if (pcm_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_release: got %b expected 1", pcm_ready); end
    for (int f = 0; f < 2; f++) begin
      run_frame(1'b0, 16'h0, sdb, wsb, u, ph, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_timeout_%0d: got %b expected 1", f, ok); end
      n_checks++; if (sdb !== 64'h0) begin n_fail++; $display("FAIL mid_zero_frame_%0d: got %h expected 0", f, sdb); end
      n_checks++; if (u !== 1) begin n_fail++; $display("FAIL mid_underrun_%0d: got %0d expected 1", f, u); end
    end
  endtask

  initial begin
    test_reset();
    test_single_sample();
    test_underrun();
    test_back_to_back();
    test_coincident_push();
    test_clock();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/i2s_transmit.md
Name: i2s_transmit

Overview:
- I2S master transmitter: the playback-direction counterpart of the microphone capture path.
- Accepts PCM samples over a valid/ready handshake into a small FIFO.
- Generates i2s_clk and i2s_ws from the system clock and serialises each sample MSB-first on i2s_sd, Philips I2S format.
- Mono: the same sample is sent on the left and right channels; it drives an external DAC/amplifier.

Parameters:
- DATA_IN_SIZE, 16, PCM input width; must be <= I2S_DATA_SIZE.
- I2S_DATA_SIZE, 24, serial word bits per channel slot; must be <= 32.
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- I2S_CLK_FREQ, 1_500_000, target SCK frequency in Hz.
- FIFO_DEPTH, 4, input FIFO entries; must be a power of two, >= 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- pcm_in  input  DATA_IN_SIZE  signed PCM sample.
- pcm_valid  input  1  pcm_in valid.
- pcm_ready  output  1  FIFO can accept a sample.
- i2s_clk  output  1  serial clock (SCK).
- i2s_ws  output  1  word select; 0 = left, 1 = right.
- i2s_sd  output  1  serial data.
- underrun  output  1  one-clk pulse: frame started with the FIFO empty.

Behaviour:
- Reset (async, rst_n low): i2s_clk=0, i2s_ws=0, i2s_sd=0, pcm_ready=0, underrun=0, FIFO empty, shift word=0, slot counter=63, divider=0.
- Divider: HALF_DIV = CLK_FREQ/(2*I2S_CLK_FREQ), integer truncation (default 33). div_cnt counts 0..HALF_DIV-1. At HALF_DIV-1, i2s_clk toggles and div_cnt returns to 0.
  - SCK period = 2*HALF_DIV clk.
  - A "fall event" is a cycle in which i2s_clk toggles 1->0.
- Slot counter s, 0..63, advances modulo 64 on each fall event. All serial outputs are registered and update only on fall events, in the same cycle i2s_clk goes low. The receiver samples on the rising edge.
- i2s_ws = 1 when the new s is in 31..62, else 0. WS therefore leads each channel's MSB by one SCK.
- i2s_sd for the new s:
  - s 0..I2S_DATA_SIZE-1: word[I2S_DATA_SIZE-1-s].
  - s 32..32+I2S_DATA_SIZE-1: word[I2S_DATA_SIZE-1-(s-32)].
  - Otherwise: 0.
- Frame load on the fall event where s becomes 63:
  - FIFO non-empty: pop; word = {pcm_in_entry, (I2S_DATA_SIZE-DATA_IN_SIZE) zeros} (left-justified, sign preserved).
  - FIFO empty: word = 0 and underrun pulses high for exactly that one clk.
- Frame period = 128*HALF_DIV clk (4224 at defaults). Sample rate = CLK_FREQ/(128*HALF_DIV).
- Handshake:
  - pcm_ready is registered; it equals "FIFO not full" as computed for the next cycle.
  - It rises the first clk after reset release.
  - A push occurs when pcm_valid && pcm_ready. pcm_in may change freely when not pushed.
- Simultaneous events:
  - Push and pop in the same cycle on a non-empty, non-full FIFO: count unchanged.
  - Pop while full: pcm_ready rises the next cycle.
  - Push into an empty FIFO in the same cycle as a frame load: no bypass, so the load underruns and the pushed sample is used next frame.
- Latency: a sample accepted before the load point appears as its MSB on i2s_sd at the next s=0 fall event, one SCK after the load.
- The first frame after reset always transmits zeros.
- Reset asserted mid-frame: all state is cleared immediately and FIFO contents are discarded.

Optional Feature:
- Macro: I2S_TRANSMIT_HOLD_LAST_EN.
- Defined: on underrun, word keeps the previously loaded sample (the last sample repeats) instead of 0. underrun still pulses.
- Undefined: on underrun, word = 0.

Decomposition:
- Package i2s_pkg holds:
  - SLOTS_PER_FRAME=64, SLOTS_PER_CHANNEL=32, LOAD_SLOT=63, WS_RISE_SLOT=31.
  - Function calc_half_div(clk_freq, sck_freq).
  - Typedef slot_t (6-bit).
- One sub-module, i2s_tx_fifo: synchronous FIFO (DATA_IN_SIZE wide, FIFO_DEPTH deep) with push, pop, full, empty and a registered next-full output.

Test Plan (defaults, HALF_DIV=33):
- Push 0x8001 once after reset -> the frame after next: left slots 0..23 shift 0x800100 MSB-first, right slots 32..55 repeat it, slots 24..31 and 56..63 = 0; i2s_ws low for s=63,0..30.
- Clock check: measure i2s_clk -> period 66 clk, 50% duty; i2s_ws period 4224 clk; i2s_ws transitions coincide with i2s_clk falling edges only.
- pcm_valid held high with pcm_in incrementing from 1 -> 4 accepted, then pcm_ready low. After each load, exactly one more is accepted. Serial stream shows 1,2,3,4,5 in consecutive frames with none lost.
- No pushes after one sample -> underrun pulses one clk per frame. Following frames are zeros, or repeat the sample with I2S_TRANSMIT_HOLD_LAST_EN defined.
- Push timed into the same cycle as the s->63 load with the FIFO empty -> underrun=1 that frame; the sample appears one frame later.
- Assert rst_n low mid-right-channel with FIFO holding 3 samples -> all outputs 0 immediately. After release, pcm_ready=1 next clk, the old samples are never transmitted, and the first frame is zeros.
